// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: FSM/owner encodings and counter sizing shared by the arbiter,
// stall logic and testbench.
package mem_port_arbiter_pkg;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_RESP = 2'd2} state_t;
   typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;
   function automatic int cnt_w(input int lat);
      return $clog2(lat) + 1;
   endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch port, data port and backing-memory bus of the arbiter.
interface mem_port_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_rdata;
   logic              i_ready;
   logic              i_stall;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ready;
   logic              d_stall;
   logic              mem_valid;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output i_rdata, i_ready, i_stall, d_rdata, d_ready, d_stall,
             mem_valid, mem_we, mem_addr, mem_wdata
   );
   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  i_rdata, i_ready, i_stall, d_rdata, d_ready, d_stall,
             mem_valid, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// mem_lat_counter: loads MEM_LATENCY-1 on a grant and counts down while the memory is busy.
module mem_lat_counter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MEM_LATENCY = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_load,
   input  logic i_en,
   output logic o_done
);
   localparam int CW = cnt_w(MEM_LATENCY);
   logic [CW-1:0] r_cnt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_cnt <= '0;
      else if (i_load) r_cnt <= CW'(MEM_LATENCY - 1);
      else if (i_en && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
   end
   assign o_done = (r_cnt == '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-port memory between the fetch and data
// ports; data wins contention until fetch has been passed over STARVE_MAX times.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 4,
   parameter int STARVE_MAX  = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   mem_port_arbiter_if.slave  bus
);
   localparam int SW = $clog2(STARVE_MAX + 1);
   state_t            r_state;
   owner_t            r_owner;
   logic [SW-1:0]     r_starve;
   logic              r_valid;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_i_rdata;
   logic [DATA_W-1:0] r_d_rdata;
   logic              r_i_ready;
   logic              r_d_ready;
   logic              w_any_req;
   logic              w_grant_i;
   logic              w_load;
   logic              w_busy;
   logic              w_done;
   assign w_any_req = bus.i_req | bus.d_req;
   assign w_grant_i = bus.i_req & (~bus.d_req | (r_starve == SW'(STARVE_MAX)));
   assign w_load    = (r_state == ST_IDLE) & w_any_req;
   assign w_busy    = (r_state == ST_BUSY);
   mem_lat_counter #(.MEM_LATENCY(MEM_LATENCY)) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_load),
      .i_en   (w_busy),
      .o_done (w_done)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_owner   <= OWN_I;
         r_starve  <= '0;
         r_valid   <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_i_rdata <= '0;
         r_d_rdata <= '0;
         r_i_ready <= 1'b0;
         r_d_ready <= 1'b0;
      end else begin
         r_i_ready <= 1'b0;
         r_d_ready <= 1'b0;
         case (r_state)
            ST_IDLE: if (w_any_req) begin
               r_state  <= ST_BUSY;
               r_valid  <= 1'b1;
               r_owner  <= w_grant_i ? OWN_I : OWN_D;
               r_addr   <= w_grant_i ? bus.i_addr : bus.d_addr;
               r_we     <= ~w_grant_i & bus.d_we;
               r_wdata  <= w_grant_i ? '0 : bus.d_wdata;
               // starvation only accrues while fetch is actually waiting
               r_starve <= w_grant_i ? '0 :
                           (bus.i_req && r_starve != SW'(STARVE_MAX)) ? r_starve + 1'b1 : r_starve;
            end
            ST_BUSY: if (w_done) begin
               r_state   <= ST_RESP;
               r_valid   <= 1'b0;
               r_i_ready <= (r_owner == OWN_I);
               r_d_ready <= (r_owner == OWN_D);
               if (!r_we && r_owner == OWN_I) r_i_rdata <= bus.mem_rdata;
               if (!r_we && r_owner == OWN_D) r_d_rdata <= bus.mem_rdata;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
   assign bus.mem_valid = r_valid;
   assign bus.mem_we    = r_we;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
   assign bus.i_rdata   = r_i_rdata;
   assign bus.d_rdata   = r_d_rdata;
   assign bus.i_ready   = r_i_ready;
   assign bus.d_ready   = r_d_ready;
   assign bus.i_stall   = bus.i_req & ~r_i_ready;
   assign bus.d_stall   = bus.d_req & ~r_d_ready;
endmodule
